adder_axis_accum: RTL
=====================

// Module: adder_axis_accum
// PURPOSE
//   Downstream consumer of the pipelined AXI-Stream adder's sum stream.
//   Sums BLOCK_LEN consecutive sums into one total and emits it on an
//   AXI-Stream output. tuser carries the sample count.
//   flush_i emits a partial block early.
// PARAMETERS
//   ADDER_WIDTH    4                              adder operand width
//   SUM_WIDTH      ADDER_WIDTH+1                  significant bits of one input sum
//   IN_AXIS_WIDTH  ceil(SUM_WIDTH/8)*8            sum_i_tdata width
//   BLOCK_LEN      4                              samples per block, >=2
//   ACC_WIDTH      SUM_WIDTH+$clog2(BLOCK_LEN)    accumulator width, cannot overflow
//   OUT_AXIS_WIDTH ceil(ACC_WIDTH/8)*8            acc_o_tdata width
//   CNT_WIDTH      $clog2(BLOCK_LEN+1)            acc_o_tuser width
// PORTS
//   aclk          in   1               clock, rising edge
//   areset        in   1               synchronous reset, active-high
//   sum_i_tdata   in   IN_AXIS_WIDTH   input sum; only [SUM_WIDTH-1:0] used, unsigned
//   sum_i_tvalid  in   1               input valid
//   sum_i_tready  out  1               input ready
//   flush_i       in   1               1-cycle pulse: emit partial block
//   acc_o_tdata   out  OUT_AXIS_WIDTH  block total, zero-extended
//   acc_o_tuser   out  CNT_WIDTH       number of samples in the total (1..BLOCK_LEN)
//   acc_o_tvalid  out  1               output valid
//   acc_o_tready  in   1               downstream ready
// BEHAVIOUR
//   - Reset, sampled on aclk while areset=1:
//     acc, cnt, acc_o_tdata, acc_o_tuser, acc_o_tvalid <= 0; FSM -> ACCUM.
//     sum_i_tready = 0 while areset=1.
//     Reset mid-block discards the partial block and any held output.
//   - Transfers: a transfer occurs when tvalid & tready are both 1 on a rising edge.
//     tvalid never depends on tready.
//     acc_o_tdata/tuser stay stable while acc_o_tvalid & !acc_o_tready.
//   - out_stall = acc_o_tvalid & !acc_o_tready.
//   - sum_i_tready = !areset & state==ACCUM & !(cnt==BLOCK_LEN-1 & out_stall).
//     This is combinational from acc_o_tready only.
//   - Accept with cnt<BLOCK_LEN-1: acc <= acc+sum; cnt++.
//   - Accept with cnt==BLOCK_LEN-1 (block completes):
//     acc_o_tdata <= acc+sum; acc_o_tuser <= BLOCK_LEN; acc_o_tvalid <= 1;
//     acc <= 0; cnt <= 0.
//     Latency: result valid 1 cycle after the last accept. A full block takes
//     BLOCK_LEN back-to-back cycles with no bubble while the output drains.
//   - Output register: acc_o_tvalid clears on an output transfer unless a new
//     result loads in the same cycle; the new result wins, with tvalid kept at 1.
//   - FSM states:
//     ACCUM: flush_i=1 -> FLUSH (flush request is registered).
//            A sample accepted in the same cycle as flush_i is included in the flush.
//     FLUSH: sum_i_tready=0.
//            If cnt==0 (includes the case where the block completed on the
//            flush cycle): -> ACCUM with no output; an empty block is never emitted.
//            Else, if !out_stall: load acc/cnt to output (tvalid=1, tuser=cnt);
//            acc,cnt <= 0; -> ACCUM.
//            Else stay in FLUSH.
//   - flush_i while in FLUSH is ignored.
// STRUCTURE
//   - Package adder_axis_pkg: axis_width(w) function (round up to a multiple of 8);
//     state typedef {ACCUM, FLUSH}; shared by all adder_axis_* blocks.
//   - One sub-module, axis_hold_reg: output data/user/valid holding register
//     with load/ready logic. Accumulator and FSM live in the top module.
// TESTING (ADDER_WIDTH=4, BLOCK_LEN=4 -> ACC 7b, OUT 8b, tuser 3b)
//   1. Send 1,2,3,4 back-to-back, acc_o_tready=1
//      -> acc_o_tdata=10, tuser=4, valid 1 cycle after 4th accept.
//   2. Send 31 x4, with tdata[7:5]=3'b111 -> 124 (0x7C); no wrap; upper bits ignored.
//   3. acc_o_tready=0, send 8 samples -> 7 accepted; 8th stalls (tready=0) and
//      first total is held. Raise tready -> 8th accepted; 2nd total follows next cycle.
//   4. Send 5,6 then flush_i -> output 11, tuser=2.
//      flush_i with cnt=0 -> no output.
//   5. Send 2 samples, areset 1 cycle, then 1,1,1,1 -> output 4, tuser=4; no stale data.
//   6. flush_i coincident with the 4th sample accept -> exactly one output (tuser=4);
//      sum_i_tready low 1 cycle.

Source files
------------

// File: rtl/adder_axis_pkg.sv
// Shared types and helpers for the adder_axis_* family of stream blocks.
// Provides AXI-Stream byte-rounding of widths and the accumulator FSM states.
package adder_axis_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Round a bit width up to a whole number of bytes, as AXI-Stream tdata requires.
  function automatic int axis_width(input int w);
    return ((w + 7) / 8) * 8;
  endfunction

endpackage

// File: rtl/axis_hold_reg.sv
// Output holding register for an AXI-Stream source: data/user/valid with
// load priority over drain, so a new result can replace one leaving this cycle.
module axis_hold_reg #(
  parameter int DATA_W = 8,
  parameter int USER_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [USER_W-1:0] i_user,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [USER_W-1:0] o_user,
  output logic              o_valid,
  output logic              o_stall
);

  logic [DATA_W-1:0] r_data;
  logic [USER_W-1:0] r_user;
  logic              r_valid;

  // Callers only assert i_load when the register is empty or draining, so a
  // held (stalled) beat is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_user  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_user  <= i_user;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_user  = r_user;
  assign o_valid = r_valid;
  assign o_stall = r_valid & ~i_ready;

endmodule

// File: rtl/adder_axis_accum.sv
// Block accumulator for the adder's sum stream: totals BLOCK_LEN sums per output
// beat (tuser = sample count); flush_i emits a partial block early.
module adder_axis_accum
  import adder_axis_pkg::*;
#(
  parameter  int ADDER_WIDTH    = 4,
  parameter  int BLOCK_LEN      = 4,
  localparam int SUM_WIDTH      = ADDER_WIDTH + 1,
  localparam int IN_AXIS_WIDTH  = axis_width(SUM_WIDTH),
  localparam int ACC_WIDTH      = SUM_WIDTH + $clog2(BLOCK_LEN),
  localparam int OUT_AXIS_WIDTH = axis_width(ACC_WIDTH),
  localparam int CNT_WIDTH      = $clog2(BLOCK_LEN + 1)
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [IN_AXIS_WIDTH-1:0]  sum_i_tdata,
  input  logic                      sum_i_tvalid,
  output logic                      sum_i_tready,
  input  logic                      flush_i,
  output logic [OUT_AXIS_WIDTH-1:0] acc_o_tdata,
  output logic [CNT_WIDTH-1:0]      acc_o_tuser,
  output logic                      acc_o_tvalid,
  input  logic                      acc_o_tready
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BLOCK_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(BLOCK_LEN);

  state_t                    r_state, w_state_next;
  logic [ACC_WIDTH-1:0]      r_acc;
  logic [CNT_WIDTH-1:0]      r_cnt;
  logic [ACC_WIDTH-1:0]      w_sum, w_acc_sum;
  logic [IN_AXIS_WIDTH-1:0]  w_unused_tdata;
  logic                      w_last, w_accept, w_out_stall, w_flush_load, w_load;
  logic [OUT_AXIS_WIDTH-1:0] w_load_data;
  logic [CNT_WIDTH-1:0]      w_load_user;

  // Only the low SUM_WIDTH bits carry the sum; the byte padding above is ignored.
  assign w_unused_tdata = sum_i_tdata;
  assign w_sum          = ACC_WIDTH'(sum_i_tdata[SUM_WIDTH-1:0]);
  assign w_acc_sum      = r_acc + w_sum;
  assign w_last         = (r_cnt == LAST_CNT);

  // Handshake: a beat moves on a rising edge where tvalid & tready are both 1;
  // tvalid never looks at tready. Input ready stalls only when the block-closing
  // sample would have nowhere to go, so partial blocks keep filling under stall.
  assign sum_i_tready = !areset && (r_state == ACCUM) && !(w_last && w_out_stall);
  assign w_accept     = sum_i_tvalid && sum_i_tready;
  assign w_flush_load = (r_state == FLUSH) && (r_cnt != '0) && !w_out_stall;
  assign w_load       = (w_accept && w_last) || w_flush_load;

  always_comb begin
    w_load_data = OUT_AXIS_WIDTH'(r_acc);
    w_load_user = r_cnt;
    if (w_accept && w_last) begin
      w_load_data = OUT_AXIS_WIDTH'(w_acc_sum);
      w_load_user = FULL_CNT;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM: if (flush_i) w_state_next = FLUSH;
      FLUSH: if ((r_cnt == '0) || !w_out_stall) w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        if (w_last) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_acc_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (w_flush_load) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end
  end

  axis_hold_reg #(
    .DATA_W (OUT_AXIS_WIDTH),
    .USER_W (CNT_WIDTH)
  ) u_hold (
    .clk     (aclk),
    .rst     (areset),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_user  (w_load_user),
    .i_ready (acc_o_tready),
    .o_data  (acc_o_tdata),
    .o_user  (acc_o_tuser),
    .o_valid (acc_o_tvalid),
    .o_stall (w_out_stall)
  );

endmodule
